// File: rtl/mult16_seq.sv
// mult16_seq: iterative unsigned 16x16->32 shift-and-add multiplier.
//
// The block has no adder of its own. In every RUN cycle it presents the
// partial product (add_a) and the gated multiplicand (add_b) to the shared
// 16-bit carry-lookahead adder. It then takes back the sum and the group
// generate/propagate bits. One multiplier bit is retired per cycle.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake (ready only in IDLE)
//   in_mcand, in_mplr    16-bit unsigned multiplicand / multiplier
//   out_valid/out_ready  product handshake (product held until accepted)
//   out_prod             32-bit product {acc, lo}
//   add_a, add_b, add_cin  operands driven to the shared adder
//   add_sum, add_g, add_p  adder sum and group generate/propagate
//
// Build option:
//   MULT_EARLY_EXIT_EN   when defined, RUN ends as soon as the remaining
//                        multiplier bits are all zero. The partial product
//                        is then aligned with a single shift. The product
//                        is the same in both builds; only latency changes.
module mult16_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_mcand,
    input  logic [15:0] in_mplr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_prod,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_cin,
    input  logic [15:0] add_sum,
    input  logic        add_g,
    input  logic        add_p
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_acc;
    logic [15:0] r_lo;
    logic [15:0] r_mcand;
    logic [15:0] r_mplr;
    logic [4:0]  r_count;

    logic        w_cout;
    logic        w_last;
    logic [31:0] w_run_nxt;

    // Carry-out of the adder is bit 16 of the partial sum.
    assign w_cout = add_g | (add_p & add_cin);

`ifdef MULT_EARLY_EXIT_EN
    logic w_mplr_empty;
    assign w_mplr_empty = (r_mplr == 16'd0);
    assign w_last       = w_mplr_empty | (r_count == 5'd15);
`else
    assign w_last       = (r_count == 5'd15);
`endif

    // Next {acc, lo} for a RUN cycle: add-and-shift, or the early-exit alignment shift.
    always_comb begin
        w_run_nxt = {w_cout, add_sum, r_lo[15:1]};
`ifdef MULT_EARLY_EXIT_EN
        // With no multiplier bits left, the remaining iterations only shift
        // right. Collapse them into one shift by (16 - count).
        if (w_mplr_empty) begin
            w_run_nxt = {r_acc, r_lo} >> (5'd16 - r_count);
        end else begin
            w_run_nxt = {w_cout, add_sum, r_lo[15:1]};
        end
`endif
    end

    // Next-state logic of the IDLE/RUN/DONE controller.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: operand capture in IDLE, one iteration per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= 16'd0;
            r_lo    <= 16'd0;
            r_mcand <= 16'd0;
            r_mplr  <= 16'd0;
            r_count <= 5'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_acc   <= 16'd0;
                        r_lo    <= 16'd0;
                        r_mcand <= in_mcand;
                        r_mplr  <= in_mplr;
                        r_count <= 5'd0;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_run_nxt[31:16];
                    r_lo    <= w_run_nxt[15:0];
                    r_mplr  <= {1'b0, r_mplr[15:1]};
                    r_count <= r_count + 5'd1;
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    // Outputs decode directly from registers. The product stays stable in DONE.
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_prod  = {r_acc, r_lo};
    assign add_a     = r_acc;
    assign add_b     = ((r_state == ST_RUN) && r_mplr[0]) ? r_mcand : 16'd0;
    assign add_cin   = 1'b0;

endmodule

// File: tb/tb_mult16_seq.sv
// Self-checking bench for mult16_seq. It includes a behavioural model of the
// shared 16-bit adder. Products are compared with a*b, and latency with the
// RUN length the build should have.
module tb_mult16_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_mcand;
    logic [15:0] in_mplr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_prod;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_g;
    logic        add_p;

    int n_checks = 0;
    int n_fail   = 0;

    mult16_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mcand  (in_mcand),
        .in_mplr   (in_mplr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_g     (add_g),
        .add_p     (add_p)
    );

    // Behavioural adder: sum, group generate (carry with cin=0) and group propagate.
    logic [16:0] ab_sum17;
    assign ab_sum17 = {1'b0, add_a} + {1'b0, add_b};
    assign add_sum  = ab_sum17[15:0] + {15'd0, add_cin};
    assign add_g    = ab_sum17[16];
    assign add_p    = &(add_a ^ add_b);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected RUN length for a given multiplier.
    function automatic int exp_lat(input logic [15:0] b);
`ifdef MULT_EARLY_EXIT_EN
        int m;
        if (b == 16'd0) return 1;
        m = 0;
        for (int i = 0; i < 16; i++) if (b[i]) m = i;
        return (m + 2 < 16) ? m + 2 : 16;
`else
        return 16;
`endif
    endfunction

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] wa;
        logic [31:0] wb;
        wa = {16'd0, a};
        wb = {16'd0, b};
        return wa * wb;
    endfunction

    // Drives one operand pair and collects the product and the cycles from acceptance to out_valid.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] prod, output int lat, output bit tmo);
        int w;
        tmo  = 1'b0;
        lat  = 0;
        prod = 32'd0;
        w    = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) begin
            tmo = 1'b1;
            return;
        end
        in_mcand = a;
        in_mplr  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) begin
            tmo = 1'b1;
            return;
        end
        prod      = out_prod;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] p;
        int          lat;
        bit          tmo;
        rst_n = 1'b0;
        #12;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_prod !== 32'd0) begin n_fail++; $display("FAIL rst_out_prod: got %h want 0", out_prod); end
        n_checks++; if ({add_a, add_b, add_cin} !== 33'd0) begin n_fail++; $display("FAIL rst_adder_ops: got %h/%h/%b want 0", add_a, add_b, add_cin); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        // Start 0x1234 x 0x5678 and reset in the middle of RUN.
        in_mcand = 16'h1234;
        in_mplr  = 16'h5678;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_busy: got ready=%b valid=%b want 0/0", in_ready, out_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_prod !== 32'd0) begin n_fail++; $display("FAIL midrst_out_prod: got %h want 0", out_prod); end
        n_checks++; if ({add_a, add_b} !== 32'd0) begin n_fail++; $display("FAIL midrst_adder_ops: got %h/%h want 0", add_a, add_b); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(16'd3, 16'd5, p, lat, tmo);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL post_rst_timeout: got %b want 0", tmo); end
        n_checks++; if (p !== 32'h0000000F) begin n_fail++; $display("FAIL post_rst_prod: got %h want 0000000f", p); end
        n_checks++; if (lat != exp_lat(16'd5)) begin n_fail++; $display("FAIL post_rst_latency: got %0d want %0d", lat, exp_lat(16'd5)); end
    endtask

    task automatic test_max;
        logic [31:0] p;
        int          lat;
        bit          tmo;
        do_op(16'hFFFF, 16'hFFFF, p, lat, tmo);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL max_timeout: got %b want 0", tmo); end
        n_checks++; if (p !== 32'hFFFE0001) begin n_fail++; $display("FAIL max_prod: got %h want fffe0001", p); end
        n_checks++; if (lat != 16) begin n_fail++; $display("FAIL max_latency: got %0d want 16", lat); end
    endtask

    task automatic test_carry;
        logic [31:0] p;
        int          lat;
        bit          tmo;
        do_op(16'h8000, 16'h0003, p, lat, tmo);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL carry_timeout: got %b want 0", tmo); end
        n_checks++; if (p !== 32'h00018000) begin n_fail++; $display("FAIL carry_prod: got %h want 00018000", p); end
        n_checks++; if (lat != exp_lat(16'h0003)) begin n_fail++; $display("FAIL carry_latency: got %0d want %0d", lat, exp_lat(16'h0003)); end
    endtask

    task automatic test_backpressure;
        int lat;
        lat = 0;
        in_mcand = 16'h00FF;
        in_mplr  = 16'h0101;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        n_checks++; if (lat != exp_lat(16'h0101)) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", lat, exp_lat(16'h0101)); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_mcand = 16'h1111;
            in_mplr  = 16'h2222;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold: cycle %0d got %b want 1", i, out_valid); end
            n_checks++; if (out_prod !== 32'h0000FFFF) begin n_fail++; $display("FAIL bp_prod_hold: cycle %0d got %h want 0000ffff", i, out_prod); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: cycle %0d got %b want 0", i, in_ready); end
            @(posedge clk); #1;
        end
        n_checks++; if (out_prod !== 32'h0000FFFF) begin n_fail++; $display("FAIL bp_prod_final: got %h want 0000ffff", out_prod); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise: got %b want 1", in_ready); end
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_no_accept: got in_ready %b want 1", in_ready); end
    endtask

    task automatic test_zero_one;
        logic [31:0] p;
        int          lat;
        bit          tmo;
        do_op(16'hABCD, 16'h0000, p, lat, tmo);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL zero_timeout: got %b want 0", tmo); end
        n_checks++; if (p !== 32'd0) begin n_fail++; $display("FAIL zero_prod: got %h want 0", p); end
        n_checks++; if (lat != exp_lat(16'h0000)) begin n_fail++; $display("FAIL zero_latency: got %0d want %0d", lat, exp_lat(16'h0000)); end
        do_op(16'hABCD, 16'h0001, p, lat, tmo);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL one_timeout: got %b want 0", tmo); end
        n_checks++; if (p !== 32'h0000ABCD) begin n_fail++; $display("FAIL one_prod: got %h want 0000abcd", p); end
        n_checks++; if (lat != exp_lat(16'h0001)) begin n_fail++; $display("FAIL one_latency: got %0d want %0d", lat, exp_lat(16'h0001)); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_q[$];
        bit          p_tmo;
        int          got;
        int          cyc;
        p_tmo = 1'b0;
        got   = 0;
        cyc   = 0;
        fork
            begin : producer
                for (int i = 0; i < 100; i++) begin
                    logic [15:0] a;
                    logic [15:0] b;
                    bit          acc;
                    int          w;
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    a = 16'($urandom);
                    b = 16'($urandom);
                    if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 15);
                    in_mcand = a;
                    in_mplr  = b;
                    in_valid = 1'b1;
                    w = 0;
                    do begin
                        acc = in_ready;
                        @(posedge clk); #1;
                        w++;
                    end while (!acc && w < 200);
                    in_valid = 1'b0;
                    if (acc) begin
                        exp_q.push_back(ref_mul(a, b));
                    end else begin
                        p_tmo = 1'b1;
                        break;
                    end
                end
            end
            begin : consumer
                while (got < 100 && cyc < 10000) begin
                    bit          hs;
                    logic [31:0] p;
                    logic [31:0] e;
                    out_ready = ($urandom_range(0, 3) != 0);
                    hs = out_valid && out_ready;
                    p  = out_prod;
                    @(posedge clk); #1;
                    cyc++;
                    if (hs) begin
                        got++;
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL b2b_extra: got product %h with nothing outstanding", p);
                        end else begin
                            e = exp_q.pop_front();
                            if (p !== e) begin n_fail++; $display("FAIL b2b_prod: result %0d got %h want %h", got, p, e); end
                        end
                    end
                end
                out_ready = 1'b0;
            end
        join
        n_checks++; if (p_tmo !== 1'b0) begin n_fail++; $display("FAIL b2b_accept_timeout: got %b want 0", p_tmo); end
        n_checks++; if (got != 100) begin n_fail++; $display("FAIL b2b_count: got %0d results want 100", got); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d outstanding want 0", exp_q.size()); end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mcand  = 16'd0;
        in_mplr   = 16'd0;
        out_ready = 1'b0;
        test_reset();
        test_max();
        test_carry();
        test_backpressure();
        test_zero_one();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
